// File: rtl/mem_ack_responder.sv
// Memory-side responder for the microsequencer ACK handshake.
// Services read/write strobes from an internal word-addressed RAM after a
// fixed number of wait states. ACK holds the sequencer address while an
// access is pending and drops for the single DONE cycle so it advances.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no access in flight; ACK follows req, latch request on req
//   ST_WAIT | counting wait states; req dropping aborts without side effects
//   ST_DONE | access completed; ACK=0, Done=1 for exactly one cycle
module mem_ack_responder #(
    parameter int DATAWIDTH   = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  MEM_ACK_RESPONDER_CLOCK_50,
    input  logic                  MEM_ACK_RESPONDER_RESET_InLow,
    input  logic                  MEM_ACK_RESPONDER_RD_InHigh,
    input  logic                  MEM_ACK_RESPONDER_WR_InHigh,
    input  logic [ADDR_WIDTH-1:0] MEM_ACK_RESPONDER_Address_InBus,
    input  logic [DATAWIDTH-1:0]  MEM_ACK_RESPONDER_Data_InBus,
    output logic                  MEM_ACK_RESPONDER_ACK_OutHigh,
    output logic [DATAWIDTH-1:0]  MEM_ACK_RESPONDER_Data_OutBus,
    output logic                  MEM_ACK_RESPONDER_Done_OutHigh
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATAWIDTH-1:0]    wdata_q;
    logic                    wr_q;
    logic [DATAWIDTH-1:0]    rdata_q;
    logic                    done_q;
    logic [DATAWIDTH-1:0]    mem [DEPTH];

    logic req;
    logic commit;

    assign req    = MEM_ACK_RESPONDER_RD_InHigh | MEM_ACK_RESPONDER_WR_InHigh;
    // The edge that leaves WAIT for DONE is the only edge with side effects.
    assign commit = (state == ST_WAIT) && req && (wait_cnt == 4'd0);

    // ACK is combinational so the sequencer stalls in the cycle it issues the
    // request; it is forced low while reset is held.
    assign MEM_ACK_RESPONDER_ACK_OutHigh  = MEM_ACK_RESPONDER_RESET_InLow & req & (state != ST_DONE);
    assign MEM_ACK_RESPONDER_Data_OutBus  = rdata_q;
    assign MEM_ACK_RESPONDER_Done_OutHigh = done_q;

    // Access sequencing: latch request in IDLE, count wait states, complete or abort.
    always_ff @(posedge MEM_ACK_RESPONDER_CLOCK_50 or negedge MEM_ACK_RESPONDER_RESET_InLow) begin
        if (!MEM_ACK_RESPONDER_RESET_InLow) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        addr_q   <= MEM_ACK_RESPONDER_Address_InBus;
                        wdata_q  <= MEM_ACK_RESPONDER_Data_InBus;
                        wr_q     <= MEM_ACK_RESPONDER_WR_InHigh;
                        wait_cnt <= CNT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= mem[addr_q];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge MEM_ACK_RESPONDER_CLOCK_50) begin
        if (commit && wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
